// File: rtl/dds_pkg.sv
// Shared constants for the multi-channel DDS: pipeline depth, dither LFSR
// definition and the elaboration-time sine helper used to build the table.
package dds_pkg;

  localparam int PIPE_LAT = 3;

  // x^16 + x^14 + x^13 + x^11 + 1, left-shifting Fibonacci form
  localparam int               LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

  localparam real PI = 3.14159265358979323846;

  // Magnitude of quarter-wave entry idx, evaluated only at elaboration.
  function automatic int quarter_mag(input int idx, input int addr_w, input int data_w);
    real amp;
    real ang;
    amp = real'((1 << (data_w - 1)) - 1);
    ang = 2.0 * PI * (real'(idx) + 0.5) / real'(1 << addr_w);
    return $rtoi(amp * $sin(ang) + 0.5);
  endfunction

endpackage

// File: rtl/dds_sin_lut.sv
// Phase-to-sample converter: quarter-wave table read (mirrored in odd
// quadrants) into a register, then a sign/negate output register.
module dds_sin_lut
  import dds_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ADDR_WIDTH-1:0]        phase,
  input  logic                         rd_en,
  input  logic                         out_en,
  output logic signed [DATA_WIDTH-1:0] sample
);

  localparam int QW = ADDR_WIDTH - 2;
  localparam int MW = DATA_WIDTH - 1;

  // NOTE: the table is constant logic rather than storage, so it has no reset.
  logic [MW-1:0] rom [2**QW];
  for (genvar i = 0; i < 2**QW; i++) begin : g_rom
    assign rom[i] = MW'(quarter_mag(i, ADDR_WIDTH, DATA_WIDTH));
  end

  // The half-LSB phase offset makes the mirror an exact bitwise inversion.
  logic [QW-1:0] addr;
  assign addr = phase[QW] ? ~phase[QW-1:0] : phase[QW-1:0];

  logic [MW-1:0] mag_q;
  logic          neg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q  <= '0;
      neg_q  <= 1'b0;
      sample <= '0;
    end else begin
      if (rd_en) begin
        mag_q <= rom[addr];
        neg_q <= phase[ADDR_WIDTH-1];
      end
      if (out_en) begin
        sample <= neg_q ? -$signed({1'b0, mag_q}) : $signed({1'b0, mag_q});
      end
    end
  end

endmodule

// File: rtl/dds_multi_ch.sv
// Multi-channel DDS with shadow/active tuning registers and a shared
// 3-stage sine pipeline. Optional truncation dither: define DDS_DITHER_EN.
module dds_multi_ch
  import dds_pkg::*;
#(
  parameter int  NUM_CH     = 2,
  parameter int  ACC_WIDTH  = 32,
  parameter int  ADDR_WIDTH = 12,
  parameter int  DATA_WIDTH = 12,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_wr,
  input  logic [CH_W-1:0]              cfg_ch,
  input  logic [ACC_WIDTH-1:0]         cfg_freq,
  input  logic [ADDR_WIDTH-1:0]        cfg_phase,
  input  logic                         update,
  input  logic                         sync,
  input  logic                         en,
  output logic [NUM_CH*DATA_WIDTH-1:0] dout,
  output logic                         dout_valid
);

  logic [ACC_WIDTH-1:0]         shadow_freq  [NUM_CH];
  logic [ACC_WIDTH-1:0]         active_freq  [NUM_CH];
  logic [ACC_WIDTH-1:0]         acc          [NUM_CH];
  logic [ADDR_WIDTH-1:0]        shadow_phase [NUM_CH];
  logic [ADDR_WIDTH-1:0]        active_phase [NUM_CH];
  logic [ADDR_WIDTH-1:0]        phase_d      [NUM_CH];
  logic [ADDR_WIDTH-1:0]        phase_q      [NUM_CH];
  logic signed [DATA_WIDTH-1:0] sample       [NUM_CH];
  logic [NUM_CH-1:0]            wr_hit;
  logic [PIPE_LAT-1:0]          valid_sr;

`ifdef DDS_DITHER_EN
  localparam int XW = ACC_WIDTH + LFSR_W;
  localparam int FW = ACC_WIDTH - ADDR_WIDTH;

  logic [LFSR_W-1:0] lfsr;
  logic [XW-1:0]     dith_x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  lfsr <= LFSR_SEED;
    else if (en) lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
  end

  // LFSR MSB lines up with the MSB of the discarded fraction field.
  assign dith_x = XW'(lfsr) << FW;
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [ADDR_WIDTH-1:0] trunc;
`ifdef DDS_DITHER_EN
    logic [XW-1:0] dith_sum;
    assign dith_sum = {acc[k], LFSR_W'(0)} + dith_x;
    assign trunc    = dith_sum[XW-1 -: ADDR_WIDTH];
`else
    assign trunc = acc[k][ACC_WIDTH-1 -: ADDR_WIDTH];
`endif
    assign wr_hit[k]  = cfg_wr && (int'(cfg_ch) == k);
    assign phase_d[k] = trunc + active_phase[k];

    dds_sin_lut #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lut (
      .clk    (clk),
      .rst_n  (rst_n),
      .phase  (phase_q[k]),
      .rd_en  (valid_sr[0]),
      .out_en (valid_sr[1]),
      .sample (sample[k])
    );

    assign dout[k*DATA_WIDTH +: DATA_WIDTH] = sample[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        shadow_freq[k]  <= '0;
        shadow_phase[k] <= '0;
        active_freq[k]  <= '0;
        active_phase[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking, so the update path reads the pre-edge shadow values.
      for (int k = 0; k < NUM_CH; k++) begin
        if (wr_hit[k]) begin
          shadow_freq[k]  <= cfg_freq;
          shadow_phase[k] <= cfg_phase;
        end
        if (update) begin
          active_freq[k]  <= wr_hit[k] ? cfg_freq  : shadow_freq[k];
          active_phase[k] <= wr_hit[k] ? cfg_phase : shadow_phase[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        acc[k]     <= '0;
        phase_q[k] <= '0;
      end
      valid_sr <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (sync)    acc[k] <= '0;
        else if (en) acc[k] <= acc[k] + active_freq[k];
        if (en) phase_q[k] <= phase_d[k];
      end
      valid_sr <= {valid_sr[PIPE_LAT-2:0], en};
    end
  end

  assign dout_valid = valid_sr[PIPE_LAT-1];

endmodule

// File: tb/tb_dds_multi_ch.sv
// Directed bench for dds_multi_ch; expected samples are hand-computed from
// round(2047*sin(2*pi*(p+0.5)/4096)). Built with NUM_CH=3 so cfg_ch=NUM_CH is encodable.
module tb_dds_multi_ch;

  localparam int NUM_CH = 3;
  localparam int AW     = 32;
  localparam int PW     = 12;
  localparam int DW     = 12;
  localparam int CW     = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 cfg_wr;
  logic [CW-1:0]        cfg_ch;
  logic [AW-1:0]        cfg_freq;
  logic [PW-1:0]        cfg_phase;
  logic                 update;
  logic                 sync;
  logic                 en;
  logic [NUM_CH*DW-1:0] dout;
  logic                 dout_valid;

  int n_checks = 0;
  int n_errors = 0;

  dds_multi_ch #(
    .NUM_CH     (NUM_CH),
    .ACC_WIDTH  (AW),
    .ADDR_WIDTH (PW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_wr     (cfg_wr),
    .cfg_ch     (cfg_ch),
    .cfg_freq   (cfg_freq),
    .cfg_phase  (cfg_phase),
    .update     (update),
    .sync       (sync),
    .en         (en),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int ch_val(input int k);
    logic signed [DW-1:0] s;
    s = dout[k*DW +: DW];
    return int'(s);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cfg_wr = 1'b0; cfg_ch = '0; cfg_freq = '0; cfg_phase = '0;
    update = 1'b0; sync = 1'b0; en = 1'b0;
    #2;
    check("rst_ch0", ch_val(0), 0);
    check("rst_ch1", ch_val(1), 0);
    check("rst_valid", dout_valid, 0);
    step(2);
    rst_n = 1'b1;
    step();

    // ch0 ramps one table step per cycle; ch1/ch2 idle at phase 0
    cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_freq = 32'h0010_0000; cfg_phase = '0;
    step();
    cfg_wr = 1'b0; update = 1'b1;
    step();
    update = 1'b0; en = 1'b1;
    step();
    check("lat_e1_valid", dout_valid, 0);
    step();
    check("lat_e2_valid", dout_valid, 0);
    step();
    check("lat_e3_valid", dout_valid, 1);
    check("ramp_p0", ch_val(0), 2);
    check("idle_ch1", ch_val(1), 2);
    check("idle_ch2", ch_val(2), 2);
    for (int n = 1; n <= 3072; n++) begin
      step();
      case (n)
        1:       check("ramp_p1", ch_val(0), 5);
        2:       check("ramp_p2", ch_val(0), 8);
        3:       check("ramp_p3", ch_val(0), 11);
        1023:    check("ramp_p1023", ch_val(0), 2047);
        2048:    check("ramp_p2048", ch_val(0), -2);
        3072:    check("ramp_p3072", ch_val(0), -2047);
        default: ;
      endcase
    end

    // shadow write alone must not reach the output
    cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_freq = '0; cfg_phase = 12'd1024;
    step();
    cfg_wr = 1'b0;
    step(3);
    check("noupd_ch1", ch_val(1), 2);
    update = 1'b1;
    step();
    update = 1'b0;
    step(2);
    check("upd_lat_ch1", ch_val(1), 2);
    step();
    check("upd_ch1", ch_val(1), 2047);
    check("upd_ch0_cont", ch_val(0), -2047);

    // sync restarts both channels at their offsets
    sync = 1'b1;
    step();
    sync = 1'b0;
    step(3);
    check("sync_ch0", ch_val(0), 2);
    check("sync_ch1", ch_val(1), 2047);
    step();
    check("sync_ch0_p1", ch_val(0), 5);

    // bypass write with update: doubled freq from the next increment
    cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_freq = 32'h0020_0000; cfg_phase = '0; update = 1'b1;
    step();
    cfg_wr = 1'b0; update = 1'b0;
    step(2);
    check("byp_p4", ch_val(0), 14);
    step();
    check("byp_p5", ch_val(0), 17);
    step();
    check("byp_p7", ch_val(0), 24);
    step();
    check("byp_p9", ch_val(0), 30);

    // reverse sine: sync + update + bypass write in one cycle
    cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_freq = 32'hFFF0_0000; cfg_phase = '0;
    update = 1'b1; sync = 1'b1;
    step();
    cfg_wr = 1'b0; update = 1'b0; sync = 1'b0;
    step(3);
    check("rev_p0", ch_val(0), 2);
    check("rev_ch1", ch_val(1), 2047);
    step();
    check("rev_p4095", ch_val(0), -2);
    step();
    check("rev_p4094", ch_val(0), -5);
    step();
    check("rev_p4093", ch_val(0), -8);

    // en=0: pipeline drains, then holds
    en = 1'b0;
    step();
    check("drain1_valid", dout_valid, 1);
    check("drain1_p4092", ch_val(0), -11);
    step();
    check("drain2_valid", dout_valid, 1);
    check("drain2_p4091", ch_val(0), -14);
    step();
    check("drain3_valid", dout_valid, 0);
    check("drain3_hold", ch_val(0), -14);
    step(5);
    check("idle_valid", dout_valid, 0);
    check("idle_hold", ch_val(0), -14);

    // resume: accumulator held while en was low
    en = 1'b1;
    step(2);
    check("resume_lat_valid", dout_valid, 0);
    step();
    check("resume_valid", dout_valid, 1);
    check("resume_p4090", ch_val(0), -17);

    // cfg_ch == NUM_CH must be ignored, including the update bypass
    cfg_wr = 1'b1; cfg_ch = 2'd3; cfg_freq = '0; cfg_phase = 12'd512; update = 1'b1;
    step();
    cfg_wr = 1'b0; update = 1'b0;
    step(5);
    check("badch_ch0", ch_val(0), -36);
    check("badch_ch1", ch_val(1), 2047);
    check("badch_ch2", ch_val(2), 2);

    // asynchronous reset mid-run
    #3;
    rst_n = 1'b0; en = 1'b0;
    #1;
    check("amid_ch0", ch_val(0), 0);
    check("amid_ch1", ch_val(1), 0);
    check("amid_valid", dout_valid, 0);
    step();
    rst_n = 1'b1;
    step();
    en = 1'b1; update = 1'b1;
    step();
    update = 1'b0;
    check("post_e1_valid", dout_valid, 0);
    step();
    check("post_e2_valid", dout_valid, 0);
    step();
    check("post_e3_valid", dout_valid, 1);
    check("post_ch0", ch_val(0), 2);
    check("post_ch1", ch_val(1), 2);
    step();
    check("post_shadow_ch1", ch_val(1), 2);
    check("post_shadow_ch0", ch_val(0), 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dds_multi_ch.md
DDS_MULTI_CH -- requirements
Module: dds_multi_ch

Interface
REQ-001 SHALL provide parameter NUM_CH, default 2, number of independent DDS channels (1..8).
REQ-002 SHALL provide parameter ACC_WIDTH, default 32, phase-accumulator width.
REQ-003 SHALL provide parameter ADDR_WIDTH, default 12, phase width after truncation, >= 4.
REQ-004 SHALL provide parameter DATA_WIDTH, default 12, signed sample width.
REQ-005 SHALL provide clk  input  1  clock; rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL provide cfg_wr  input  1  shadow-register write strobe.
REQ-007 SHALL provide cfg_ch  input  $clog2(NUM_CH) (min 1)  target channel of cfg_wr.
REQ-008 SHALL provide cfg_freq  input  ACC_WIDTH  frequency tuning word.
REQ-009 SHALL provide cfg_phase  input  ADDR_WIDTH  phase offset.
REQ-010 SHALL provide update  input  1  copy all shadow registers to active registers.
REQ-011 SHALL provide sync  input  1  clear all accumulators.
REQ-012 SHALL provide en  input  1  accumulate enable.
REQ-013 SHALL provide dout  output  NUM_CH*DATA_WIDTH  signed samples, channel k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-014 SHALL provide dout_valid  output  1  dout holds a sample produced with en=1.

Function
REQ-015 SHALL write cfg_freq/cfg_phase into channel cfg_ch shadow registers on a cfg_wr cycle; cfg_ch >= NUM_CH ignored.
REQ-016 SHALL load all active freq/phase from shadow on an update cycle; cfg_wr in the same cycle bypasses, so its value is loaded.
REQ-017 SHALL update each accumulator as acc <= acc + active_freq (mod 2^ACC_WIDTH, natural wrap) when en=1, hold when en=0.
REQ-018 SHALL clear all accumulators to 0 when sync=1, priority over en; sync with update: cleared, new freq used from the following increment.
REQ-019 SHALL form phase = acc[ACC_WIDTH-1 -: ADDR_WIDTH] + active_phase, mod 2^ADDR_WIDTH.
REQ-020 SHALL map phase p to round((2^(DATA_WIDTH-1)-1) * sin(2*pi*(p+0.5)/2^ADDR_WIDTH)), two's complement.
REQ-021 SHALL realise REQ-020 with a quarter-wave table of 2^(ADDR_WIDTH-2) entries plus quadrant mirror (bit ADDR_WIDTH-2) and negate (MSB).
REQ-022 SHALL pipeline as: phase register, table read register, sign/negate output register; dout reflects accumulator value 3 cycles earlier.
REQ-023 SHALL assert dout_valid exactly 3 cycles after a cycle with en=1; all channels share one timing.
REQ-024 SHALL keep dout unchanged while dout_valid=0 after pipeline drains.

Reset
REQ-025 SHALL clear, on rst_n low, all accumulators, shadow and active registers, pipeline registers, dout and dout_valid to 0.
REQ-026 SHALL abandon in-flight samples on reset mid-operation; first valid sample is 3 cycles after the first en cycle after release.

Configuration
REQ-027 SHALL, with DDS_DITHER_EN defined, add a 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset, advancing every en cycle) aligned to the MSBs of the truncated fraction field before truncation; accumulators unaffected.
REQ-028 SHALL, without DDS_DITHER_EN, contain no LFSR and truncate with no dither.

Structure
REQ-029 SHALL place pipeline latency constant (3), LFSR polynomial and seed in package dds_pkg.
REQ-030 SHALL instantiate sub-module dds_sin_lut (quarter-wave table, mirror, negate) once per channel.

Verification (defaults, DDS_DITHER_EN undefined)
REQ-031 SHALL check: reset, cfg_wr ch0 freq=2^20 phase=0, update, en=1 -> dout_valid rises 3 cycles after en; ch0 samples 2,...,2047 at phase 1023, -2 at 2048, -2047 at 3072.
REQ-032 SHALL check: ch1 phase=1024, freq=0, update, en=1 -> ch1 constant 2047; ch0 unaffected.
REQ-033 SHALL check: cfg_wr without update -> outputs unchanged; update -> new freq effective on next accumulator step, visible 3 cycles later.
REQ-034 SHALL check: freq=32'hFFF0_0000 -> accumulator wraps, phase decrements by 1 per cycle (reverse sine).
REQ-035 SHALL check: sync pulse mid-run -> both channels restart at phase-offset value, coherent; en=0 -> samples hold, dout_valid drops after 3 cycles.
REQ-036 SHALL check: rst_n asserted mid-run -> dout=0, dout_valid=0 immediately; cfg_ch=NUM_CH write ignored.
